// File: rtl/macguffin_decrypt.sv
// Iterative MacGuffin block decryptor.
// A ciphertext is accepted in IDLE. RUN applies one inverse Feistel round per
// clock, fetching round keys from the external store in the order ROUNDS-1..0.
// DONE holds the plaintext until the consumer takes it.

// One 6-in/2-out S-box. The contents are a 64-entry table of 2-bit values.
module macguffin_sbox #(
  parameter logic [127:0] TABLE = '0
) (
  input  logic [5:0] sin_i,
  output logic [1:0] sout_o
);
  assign sout_o = TABLE[{sin_i, 1'b0} +: 2];
endmodule

module macguffin_decrypt #(
  parameter  int ROUNDS = 32,
  localparam int CW     = $clog2(ROUNDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  output logic [CW-1:0] rk_idx,
  input  logic [47:0]   rk,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // S-box input taps: per box two bits of each masked word (a, a, b, b, c, c),
  // first tap is the MSB of the 6-bit index. Box j drives F bits [2j+1:2j].
  // This table and the S-box contents are shared with the encryptor.
  localparam int SBIT [8][6] = '{
    '{ 2,  5,  6,  9, 11, 13}, '{ 1,  4,  7, 10,  8, 14},
    '{ 3,  6,  8, 13,  0, 15}, '{12, 14,  1,  2,  4, 10},
    '{ 0, 10,  3, 14,  6, 12}, '{ 7,  8, 12, 15,  1,  5},
    '{ 9, 15,  5, 11,  2,  7}, '{11, 13,  0,  4,  3,  9}
  };
  localparam logic [127:0] STAB [8] = '{
    128'hc6a53e917b08d24f59e3a01c8f762db4,
    128'h1f8e2d7c4b3a6958e7d6c5b4a3928170,
    128'h93b7e1c5d02f4a6878ac13f5b9e64d20,
    128'h5e0a9fc3872d1b46e4c8306f7a91d25b,
    128'h2b74e91f06d8ca35b3590e7d48f16ac2,
    128'hd81c6f3a95e0b7424cfa1e6092d78b35,
    128'h7a3d05e8c9f41b62a6e71d3094bc58f2,
    128'h40f9b23e6c8d751a8e2c9d47f0b36a15
  };

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0][15:0] r_q, r_d;   // r_q[i] is word Ri

  logic [15:0] k0, k1, k2, fa, fb, fc, f;

  assign {k2, k1, k0} = rk;

  // After the un-rotate, R1..R3 are the current R0..R2, so F is fed directly
  // from the registered words and the round closes in a single edge.
  assign fa = r_q[0] ^ k0;
  assign fb = r_q[1] ^ k1;
  assign fc = r_q[2] ^ k2;

  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [5:0] sin;
    assign sin = {fa[SBIT[j][0]], fa[SBIT[j][1]],
                  fb[SBIT[j][2]], fb[SBIT[j][3]],
                  fc[SBIT[j][4]], fc[SBIT[j][5]]};
    macguffin_sbox #(.TABLE(STAB[j])) u_sbox (
      .sin_i  (sin),
      .sout_o (f[2*j +: 2])
    );
  end

  // State, round counter and data words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= CW'(ROUNDS - 1);
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  // Next-state: load in IDLE, one inverse round per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d     = in_data;
          cnt_d   = CW'(ROUNDS - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        r_d[0] = r_q[3] ^ f;
        r_d[1] = r_q[0];
        r_d[2] = r_q[1];
        r_d[3] = r_q[2];
        if (cnt_q == '0) begin
          cnt_d   = CW'(ROUNDS - 1);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = r_q;
  assign rk_idx    = cnt_q;
endmodule

// File: tb/tb_macguffin_decrypt.sv
// Directed bench for macguffin_decrypt: the bench encrypts known plaintexts with
// its own forward MacGuffin model and checks the decryptor recovers them, along
// with handshake timing, key order, backpressure and reset behaviour.
module tb_macguffin_decrypt;
  localparam int ROUNDS = 32;

  localparam int SBIT [8][6] = '{
    '{ 2,  5,  6,  9, 11, 13}, '{ 1,  4,  7, 10,  8, 14},
    '{ 3,  6,  8, 13,  0, 15}, '{12, 14,  1,  2,  4, 10},
    '{ 0, 10,  3, 14,  6, 12}, '{ 7,  8, 12, 15,  1,  5},
    '{ 9, 15,  5, 11,  2,  7}, '{11, 13,  0,  4,  3,  9}
  };
  localparam logic [127:0] STAB [8] = '{
    128'hc6a53e917b08d24f59e3a01c8f762db4,
    128'h1f8e2d7c4b3a6958e7d6c5b4a3928170,
    128'h93b7e1c5d02f4a6878ac13f5b9e64d20,
    128'h5e0a9fc3872d1b46e4c8306f7a91d25b,
    128'h2b74e91f06d8ca35b3590e7d48f16ac2,
    128'hd81c6f3a95e0b7424cfa1e6092d78b35,
    128'h7a3d05e8c9f41b62a6e71d3094bc58f2,
    128'h40f9b23e6c8d751a8e2c9d47f0b36a15
  };

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] in_data, out_data;
  logic [4:0]  rk_idx;
  logic [47:0] rk;

  logic [47:0] ks     [ROUNDS];  // schedule used by the encryption model
  logic [47:0] rk_mem [ROUNDS];  // schedule presented to the DUT
  int n_cmp = 0, n_err = 0, cyc = 0;

  assign rk = rk_mem[rk_idx];

  macguffin_decrypt dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- forward model ----
  function automatic logic [15:0] f16(input logic [15:0] a, b, c);
    logic [15:0]  o;
    logic [127:0] t;
    logic [5:0]   s;
    o = '0;
    for (int j = 0; j < 8; j++) begin
      t = STAB[j];
      s = {a[SBIT[j][0]], a[SBIT[j][1]], b[SBIT[j][2]], b[SBIT[j][3]],
           c[SBIT[j][4]], c[SBIT[j][5]]};
      o[2*j +: 2] = t[2*s +: 2];
    end
    return o;
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] p);
    logic [15:0] r0, r1, r2, r3, t;
    {r3, r2, r1, r0} = p;
    for (int i = 0; i < ROUNDS; i++) begin
      r0 = r0 ^ f16(r1 ^ ks[i][15:0], r2 ^ ks[i][31:16], r3 ^ ks[i][47:32]);
      t = r0; r0 = r1; r1 = r2; r2 = r3; r3 = t;
    end
    return {r3, r2, r1, r0};
  endfunction

  // Bench key expansion: rotate/mix the 128-bit key into 32 round keys.
  task automatic expand_key(input logic [127:0] key);
    logic [127:0] k;
    k = key;
    for (int i = 0; i < ROUNDS; i++) begin
      k = {k[122:0], k[127:123]} ^ {96'h0, 32'(i) * 32'h9e3779b9};
      ks[i] = k[47:0] ^ k[127:80];
    end
  endtask

  task automatic load_store();
    for (int i = 0; i < ROUNDS; i++) rk_mem[i] = ks[i];
  endtask

  // Offer a block and return one ns after the accepting edge.
  task automatic start_block(input logic [63:0] ct, output bit ok);
    ok = 1'b0;
    in_data  = ct;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    for (int i = 0; i < ROUNDS; i++) rk_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rk_idx !== 5'd31) begin n_err++; $display("FAIL reset_rk_idx: got %0d want 31", rk_idx); end
    n_cmp++; if (out_data !== 64'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_trip();
    logic [63:0] pt, ct;
    bit ok;
    pt = 64'h0123_4567_89AB_CDEF;
    expand_key(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
    ct = encrypt(pt);
    load_store();
    start_block(ct, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rt_accept: block not accepted"); end
    // key order and latency: rk_idx 31..0, out_valid low until edge t+32
    for (int r = 0; r < ROUNDS; r++) begin
      n_cmp++; if (rk_idx !== 5'(31 - r)) begin n_err++; $display("FAIL key_order r%0d: got %0d want %0d", r, rk_idx, 31 - r); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rt_early_valid r%0d: got %b want 0", r, out_valid); end
      @(posedge clk); #1;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rt_latency: out_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== pt) begin n_err++; $display("FAIL rt_data: got %h want %h", out_data, pt); end
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL rt_done_flags: busy %b in_ready %b want 1 0", busy, in_ready); end
    n_cmp++; if (rk_idx !== 5'd31) begin n_err++; $display("FAIL rt_done_rk_idx: got %0d want 31", rk_idx); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rt_handshake: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    logic [63:0] pt2, pt3, ct2, ct3;
    bit ok;
    int k;
    pt2 = 64'hFEDC_BA98_7654_3210;
    pt3 = 64'hDEAD_BEEF_0BAD_F00D;
    expand_key(128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0);
    ct2 = encrypt(pt2);
    ct3 = encrypt(pt3);
    load_store();
    start_block(ct2, ok);
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_timeout: out_valid got %b want 1", out_valid); end
    in_data  = ct3;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (out_data !== pt2 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold c%0d: data %h valid %b want %h 1", c, out_data, out_valid, pt2); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;   // output handshake edge
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bp_after_hs: in_ready %b busy %b want 1 0", in_ready, busy); end
    @(posedge clk); #1;   // second block accepted here
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || rk_idx !== 5'd31) begin n_err++; $display("FAIL bp_accept2: busy %b rk_idx %0d want 1 31", busy, rk_idx); end
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
    n_cmp++; if (k !== 32) begin n_err++; $display("FAIL bp_latency2: got %0d want 32", k); end
    n_cmp++; if (out_data !== pt3) begin n_err++; $display("FAIL bp_data2: got %h want %h", out_data, pt3); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] pt, ct;
    bit ok;
    int seen, k;
    pt = 64'h1357_9BDF_2468_ACE0;
    expand_key(128'hA5A5_5A5A_0123_4567_89AB_CDEF_FFFF_0000);
    ct = encrypt(pt);
    load_store();
    start_block(ct, ok);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_flags: in_ready %b out_valid %b busy %b want 1 0 0", in_ready, out_valid, busy); end
    n_cmp++; if (rk_idx !== 5'd31 || out_data !== 64'h0) begin n_err++; $display("FAIL mid_reset_vals: rk_idx %0d out_data %h want 31 0", rk_idx, out_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mid_reset_no_valid: got %0d valid cycles want 0", seen); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready: got %b want 1", in_ready); end
    start_block(ct, ok);
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== pt) begin n_err++; $display("FAIL mid_reset_next: valid %b data %h want 1 %h", out_valid, out_data, pt); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] pt_cur, pt_nxt, ct;
    int acc, prev_acc, k;
    out_ready = 1'b1;
    for (int i = 0; i < ROUNDS; i++) ks[i] = {16'($urandom), 32'($urandom)};
    pt_cur = {32'($urandom), 32'($urandom)};
    ct = encrypt(pt_cur);
    load_store();
    in_data  = ct;
    in_valid = 1'b1;
    prev_acc = 0;
    for (int b = 0; b < 100; b++) begin
      k = 0;
      while (in_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;   // accepting edge
      acc = cyc;
      if (b > 0) begin
        n_cmp++; if (acc - prev_acc !== 34) begin n_err++; $display("FAIL b2b_interval b%0d: got %0d want 34", b, acc - prev_acc); end
      end
      prev_acc = acc;
      // next block prepared while this one runs; rk_mem is left alone
      for (int i = 0; i < ROUNDS; i++) ks[i] = {16'($urandom), 32'($urandom)};
      pt_nxt = {32'($urandom), 32'($urandom)};
      in_data = encrypt(pt_nxt);
      if (b == 99) in_valid = 1'b0;
      k = 0;
      while (out_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== pt_cur) begin n_err++; $display("FAIL b2b_data b%0d: valid %b data %h want 1 %h", b, out_valid, out_data, pt_cur); end
      load_store();
      pt_cur = pt_nxt;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/macguffin_decrypt.md
# macguffin_decrypt

Iterative MacGuffin block decryptor: accepts a 64-bit ciphertext over a valid/ready handshake and runs the 32 inverse Feistel rounds, one per clock. It fetches one 48-bit round key per round, in reverse order, from the external key-schedule store. It returns the 64-bit plaintext over a second valid/ready handshake. It is the receive-side counterpart of the encryptor and reuses the same S1–S8 S-box modules and F-function bit map.

## Interface
- ROUNDS, 32, number of rounds; round-counter width is $clog2(ROUNDS)
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ciphertext offered
- in_ready  output  1  decryptor can accept a block
- in_data  input  64  ciphertext; [15:0]=R0, [31:16]=R1, [47:32]=R2, [63:48]=R3
- rk_idx  output  $clog2(ROUNDS)  round-key index requested from key store
- rk  input  48  round key for rk_idx, combinational from store, same cycle; [15:0]=K0, [31:16]=K1, [47:32]=K2
- out_valid  output  1  plaintext available
- out_ready  input  1  consumer accepts plaintext
- out_data  output  64  plaintext, same word packing as in_data
- busy  output  1  high in RUN and DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: load R0..R3 from in_data and set cnt=ROUNDS-1. Next state RUN.
- RUN
  - Each cycle applies one inverse round using rk at rk_idx=cnt:
    - un-rotate: (R0,R1,R2,R3) <- (R3,R0,R1,R2);
    - then R0 <- R0 ^ F(R1^K0, R2^K1, R3^K2).
  - F: the eight S-boxes S1–S8, each fed 6 bits (2 each from the three masked words), with the 2-bit outputs placed per the team's MacGuffin F bit map. The map is identical to the encryptor's.
  - Both steps are computed combinationally from the pre-round register values and registered in one edge.
  - cnt decrements each cycle. The cycle with cnt==0 is the last round; next state DONE.
- DONE
  - out_valid=1, out_data = (R0,R1,R2,R3).
  - On out_ready: next state IDLE.
  - out_data and out_valid hold stable while out_ready=0.
- rk_idx = cnt in all states; it reads ROUNDS-1 in IDLE so the store can prefetch. rk is ignored outside RUN.
- in_ready=0 in RUN and DONE. in_valid there is ignored and the block is not consumed.
- No overlap between blocks: a new block is accepted only from IDLE.
- Reset values (asynchronous, any state):
  - state=IDLE, cnt=ROUNDS-1, R0..R3=0;
  - in_ready=1, out_valid=0, busy=0, out_data=0, rk_idx=ROUNDS-1.
- Reset mid-RUN or mid-DONE: the block is discarded and no out_valid is produced.

## Timing
- Accept at edge t (in_valid & in_ready).
- Rounds are applied at edges t+1..t+ROUNDS, with rk_idx = ROUNDS-1 down to 0.
- out_valid rises after edge t+ROUNDS: 32 cycles latency at default.
- Output handshake completes at the first edge with out_valid & out_ready; in_ready is high the following cycle.
- Minimum block interval: ROUNDS+2 cycles (accept, ROUNDS rounds, DONE handshake, then IDLE accept).
- rk must be valid in the same cycle as rk_idx; no key-fetch wait states are supported.
- All outputs are registered or decoded from registered state only. None depends combinationally on in_valid or out_ready.

## Test plan
- Reset: hold rst_n=0 mid-stream → in_ready=1, out_valid=0, busy=0, rk_idx=31, out_data=0.
- Round trip: encrypt 64'h0123_4567_89AB_CDEF with the encryptor/golden model under the key schedule of key 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, then decrypt → out_data=64'h0123_4567_89AB_CDEF; out_valid rises exactly 32 cycles after accept.
- Key order: monitor rk_idx during RUN → sequence 31,30,…,0, one per cycle, then DONE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 → out_data stable, in_ready=0, second block not consumed until one cycle after the output handshake.
- Reset mid-run: assert rst_n=0 at round 15 → out_valid never asserts for that block; after release, in_ready=1 and the next block decrypts correctly.
- Back-to-back: 100 random ciphertexts/keys with in_valid and out_ready held at 1 → all match the golden model, with a 34-cycle block interval.
